// File: rtl/ms_beat_controller.sv
// ms_beat_controller
// Beat sequencer for the main store. The w_DPG digit stream is divided into
// beats of INSTR_BITS active digits plus FLYBACK_TIME flyback digits. The
// machine steps through SCAN1, ACTION1, SCAN2, ACTION2. Between instructions
// it can stop, and while stopped it serves single-beat manual writes.
// Every output is decoded from registered state and the registered digit
// counter. The only exception is b_MS_ADDR, which also steers the selected
// address input straight through.
module ms_beat_controller #(
  parameter int INSTR_BITS      = 20,
  parameter int INSTR_ADDR_BITS = 10,
  parameter int FLYBACK_TIME    = 4,
  localparam int BEAT_LEN       = INSTR_BITS + FLYBACK_TIME,
  localparam int DIGIT_W        = $clog2(BEAT_LEN) + 1
) (
  input  logic                       w_DPG,
  input  logic                       w_RST_N,
  input  logic                       w_RUN,
  input  logic                       w_HALT,
  input  logic                       w_STORE,
  input  logic [INSTR_ADDR_BITS-1:0] b_CI,
  input  logic [INSTR_ADDR_BITS-1:0] b_PI_ADDR,
  input  logic                       w_MAN_REQ,
  input  logic [INSTR_ADDR_BITS-1:0] b_MAN_ADDR,
  output logic [INSTR_ADDR_BITS-1:0] b_MS_ADDR,
  output logic                       w_XTB,
  output logic                       w_MS_ZERO,
  output logic [DIGIT_W-1:0]         b_DIGIT,
  output logic                       w_FLYBACK,
  output logic [1:0]                 b_BEAT,
  output logic                       w_CI_INC,
  output logic                       w_PI_LOAD,
  output logic                       w_MAN_ACK,
  output logic                       w_STOPPED
);

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_MAN     = 3'd1,
    ST_SCAN1   = 3'd2,
    ST_ACTION1 = 3'd3,
    ST_SCAN2   = 3'd4,
    ST_ACTION2 = 3'd5
  } state_t;

  state_t             state_r;
  logic [DIGIT_W-1:0] digit_r;
  logic               st_f_r;
  logic               hl_f_r;
  logic               last_digit_s;

  assign last_digit_s = (digit_r == DIGIT_W'(BEAT_LEN - 1));

  // Free-running digit counter. It runs in every state so that beat
  // boundaries stay aligned to the drum even while stopped.
  always_ff @(posedge w_DPG or negedge w_RST_N) begin
    if (!w_RST_N) begin
      digit_r <= '0;
    end else if (last_digit_s) begin
      digit_r <= '0;
    end else begin
      digit_r <= digit_r + DIGIT_W'(1);
    end
  end

  // Beat state machine. It moves only on the edge that leaves the last digit.
  // The store/halt flags are captured at the end of SCAN2 and cleared when
  // ACTION2 ends.
  always_ff @(posedge w_DPG or negedge w_RST_N) begin
    if (!w_RST_N) begin
      state_r <= ST_STOP;
      st_f_r  <= 1'b0;
      hl_f_r  <= 1'b0;
    end else if (last_digit_s) begin
      case (state_r)
        ST_STOP: begin
          // A manual request takes priority over a request to run.
          if (w_MAN_REQ) begin
            state_r <= ST_MAN;
          end else if (w_RUN) begin
            state_r <= ST_SCAN1;
          end else begin
            state_r <= ST_STOP;
          end
        end
        ST_MAN:     state_r <= ST_STOP;
        ST_SCAN1:   state_r <= ST_ACTION1;
        ST_ACTION1: state_r <= ST_SCAN2;
        ST_SCAN2: begin
          state_r <= ST_ACTION2;
          st_f_r  <= w_STORE;
          hl_f_r  <= w_HALT;
        end
        ST_ACTION2: begin
          // Dropping w_RUN only takes effect here, so the current
          // instruction always completes.
          if (hl_f_r || !w_RUN) begin
            state_r <= ST_STOP;
          end else begin
            state_r <= ST_SCAN1;
          end
          st_f_r <= 1'b0;
          hl_f_r <= 1'b0;
        end
        default: begin
          state_r <= ST_STOP;
          st_f_r  <= 1'b0;
          hl_f_r  <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Decode the outputs from the registered state and the digit counter.
  // The write strobe has no path from any input, so reset removes it
  // asynchronously.
  always_comb begin
    b_MS_ADDR = b_MAN_ADDR;
    w_XTB     = 1'b0;
    b_BEAT    = 2'd0;
    w_CI_INC  = 1'b0;
    w_PI_LOAD = 1'b0;
    w_MAN_ACK = 1'b0;
    w_STOPPED = 1'b0;
    case (state_r)
      ST_STOP: begin
        w_STOPPED = 1'b1;
      end
      ST_MAN: begin
        w_XTB     = 1'b1;
        w_MAN_ACK = last_digit_s;
      end
      ST_SCAN1: begin
        b_MS_ADDR = b_CI;
        b_BEAT    = 2'd0;
        w_CI_INC  = last_digit_s;
      end
      ST_ACTION1: begin
        b_MS_ADDR = b_CI;
        b_BEAT    = 2'd1;
        w_PI_LOAD = last_digit_s;
      end
      ST_SCAN2: begin
        b_MS_ADDR = b_PI_ADDR;
        b_BEAT    = 2'd2;
      end
      ST_ACTION2: begin
        b_MS_ADDR = b_PI_ADDR;
        b_BEAT    = 2'd3;
        w_XTB     = st_f_r;
      end
      default: begin
        w_STOPPED = 1'b1;
      end
    endcase
  end

  assign w_MS_ZERO = w_XTB;
  assign b_DIGIT   = digit_r;
  assign w_FLYBACK = (digit_r >= DIGIT_W'(INSTR_BITS));

endmodule

// File: tb/tb_ms_beat_controller.sv
// Self-checking bench for ms_beat_controller. A beat-level reference model
// predicts every output on each falling edge. Directed phases pin that model
// with literal expectations. A randomized phase then exercises it further.
module tb_ms_beat_controller;

  localparam int IB   = 20;
  localparam int AW   = 10;
  localparam int FB   = 4;
  localparam int BEAT = IB + FB;
  localparam int DW   = $clog2(BEAT) + 1;

  // Beat kinds of the reference model.
  localparam int K_STOP = 0, K_MAN = 1, K_S1 = 2, K_A1 = 3, K_S2 = 4, K_A2 = 5;

  logic          clk, rst_n, run, halt, store, man_req;
  logic [AW-1:0] ci, pi_addr, man_addr;
  logic [AW-1:0] ms_addr;
  logic          xtb, ms_zero, flyback, ci_inc, pi_load, man_ack, stopped;
  logic [DW-1:0] digit;
  logic [1:0]    beat;

  int n_checks = 0;
  int n_pass   = 0;
  int tick;
  bit cmp_en   = 1'b0;

  ms_beat_controller #(.INSTR_BITS(IB), .INSTR_ADDR_BITS(AW), .FLYBACK_TIME(FB)) dut (
    .w_DPG(clk), .w_RST_N(rst_n), .w_RUN(run), .w_HALT(halt), .w_STORE(store),
    .b_CI(ci), .b_PI_ADDR(pi_addr), .w_MAN_REQ(man_req), .b_MAN_ADDR(man_addr),
    .b_MS_ADDR(ms_addr), .w_XTB(xtb), .w_MS_ZERO(ms_zero), .b_DIGIT(digit),
    .w_FLYBACK(flyback), .b_BEAT(beat), .w_CI_INC(ci_inc), .w_PI_LOAD(pi_load),
    .w_MAN_ACK(man_ack), .w_STOPPED(stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t tick=%0d", name, act, exp, $time, tick);
  endtask

  // Digits elapsed since the last reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tick <= 0;
    else        tick <= tick + 1;

  // Reference model. The machine is a sequence of whole beats. At the end of
  // each beat the next beat kind follows from the instruction-cycle rules.
  int m_kind, m_dig;
  bit m_st, m_hl;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind <= K_STOP; m_dig <= 0; m_st <= 1'b0; m_hl <= 1'b0;
    end else begin
      m_dig <= (m_dig + 1) % BEAT;
      if (m_dig == BEAT - 1) begin
        if (m_kind == K_STOP)
          m_kind <= man_req ? K_MAN : (run ? K_S1 : K_STOP);
        else if (m_kind == K_MAN)
          m_kind <= K_STOP;
        else if (m_kind == K_A2) begin
          m_kind <= (m_hl || !run) ? K_STOP : K_S1;
          m_st <= 1'b0; m_hl <= 1'b0;
        end else begin
          m_kind <= m_kind + 1;
          if (m_kind == K_S2) begin m_st <= store; m_hl <= halt; end
        end
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit last, running;
      int exp_addr;
      last     = (m_dig == BEAT - 1);
      running  = (m_kind >= K_S1);
      exp_addr = (m_kind == K_S1 || m_kind == K_A1) ? int'(ci) :
                 (m_kind == K_S2 || m_kind == K_A2) ? int'(pi_addr) : int'(man_addr);
      chk("m_digit",   32'(digit),   32'(m_dig));
      chk("m_flyback", 32'(flyback), 32'(m_dig >= IB));
      chk("m_beat",    32'(beat),    running ? 32'(m_kind - K_S1) : 32'd0);
      chk("m_stopped", 32'(stopped), 32'(m_kind == K_STOP));
      chk("m_xtb",     32'(xtb),     32'(m_kind == K_MAN || (m_kind == K_A2 && m_st)));
      chk("m_zero",    32'(ms_zero), 32'(m_kind == K_MAN || (m_kind == K_A2 && m_st)));
      chk("m_ci_inc",  32'(ci_inc),  32'(m_kind == K_S1 && last));
      chk("m_pi_load", 32'(pi_load), 32'(m_kind == K_A1 && last));
      chk("m_man_ack", 32'(man_ack), 32'(m_kind == K_MAN && last));
      chk("m_addr",    32'(ms_addr), 32'(exp_addr));
    end
  end

  // Return at falling edge +1 on the given digit since release.
  task automatic wait_digit(input int n);
    int guard;
    guard = 0;
    while (tick != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (tick != n) chk("wait_digit_timeout", 32'(tick), 32'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_stopped", 32'(stopped), 32'd1);
    chk("rst_xtb",     32'(xtb),     32'd0);
    chk("rst_digit",   32'(digit),   32'd0);
    chk("rst_beat",    32'(beat),    32'd0);
    chk("rst_addr",    32'(ms_addr), 32'(man_addr));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; halt = 1'b0; store = 1'b0; man_req = 1'b0;
    ci = 10'd7; pi_addr = 10'd5; man_addr = 10'd3;
    #12;
    cmp_en = 1'b1;

    // Idle in STOP: the digit counter still cycles.
    do_reset();
    wait_digit(19); chk("fly_19", 32'(flyback), 32'd0);
    wait_digit(20); chk("fly_20", 32'(flyback), 32'd1);
    wait_digit(23); chk("dig_23", 32'(digit), 32'd23);
    wait_digit(24); chk("dig_24", 32'(digit), 32'd0);
    wait_digit(99); chk("idle_stopped", 32'(stopped), 32'd1);
                    chk("idle_dig_99", 32'(digit), 32'd3);

    // Normal cycle, then a store instruction, then a halt.
    run = 1'b1;
    do_reset();
    wait_digit(23);  chk("n_stop_23", 32'(stopped), 32'd1);
    wait_digit(24);  chk("n_s1_beat", 32'(beat), 32'd0); chk("n_s1_run", 32'(stopped), 32'd0);
                     chk("n_s1_addr", 32'(ms_addr), 32'd7);
    wait_digit(47);  chk("n_ci_inc", 32'(ci_inc), 32'd1);
    wait_digit(48);  chk("n_a1_beat", 32'(beat), 32'd1); chk("n_a1_addr", 32'(ms_addr), 32'd7);
                     chk("n_ci_inc_off", 32'(ci_inc), 32'd0);
    wait_digit(71);  chk("n_pi_load", 32'(pi_load), 32'd1);
    wait_digit(72);  chk("n_s2_beat", 32'(beat), 32'd2); chk("n_s2_addr", 32'(ms_addr), 32'd5);
                     chk("n_s2_xtb", 32'(xtb), 32'd0);
    wait_digit(95);  store = 1'b1;
    wait_digit(96);  chk("st_a2_beat", 32'(beat), 32'd3); chk("st_xtb_96", 32'(xtb), 32'd1);
                     chk("st_zero_96", 32'(ms_zero), 32'd1); chk("st_addr", 32'(ms_addr), 32'd5);
                     store = 1'b0;
    wait_digit(119); chk("st_xtb_119", 32'(xtb), 32'd1);
    wait_digit(120); chk("st_xtb_120", 32'(xtb), 32'd0); chk("n_s1_again", 32'(beat), 32'd0);
                     chk("n_run_120", 32'(stopped), 32'd0);
    wait_digit(191); halt = 1'b1;
    wait_digit(192); chk("nost_xtb", 32'(xtb), 32'd0); halt = 1'b0;
    wait_digit(215); chk("h_run_215", 32'(stopped), 32'd0);
    wait_digit(216); chk("h_stopped", 32'(stopped), 32'd1);

    // Run drop mid-cycle, a manual request during ACTION1, then arbitration.
    run = 1'b1; man_addr = 10'd9;
    do_reset();
    wait_digit(50);  run = 1'b0;
    wait_digit(60);  man_req = 1'b1;
    wait_digit(72);  chk("rd_s2", 32'(beat), 32'd2); chk("rd_no_man", 32'(xtb), 32'd0);
    wait_digit(119); chk("rd_a2", 32'(beat), 32'd3);
    wait_digit(120); chk("rd_stopped", 32'(stopped), 32'd1);
    wait_digit(130); run = 1'b1;
    wait_digit(144); chk("man_xtb", 32'(xtb), 32'd1); chk("man_addr", 32'(ms_addr), 32'd9);
                     chk("man_not_stop", 32'(stopped), 32'd0);
    wait_digit(166); chk("man_ack_early", 32'(man_ack), 32'd0);
    wait_digit(167); chk("man_ack", 32'(man_ack), 32'd1); chk("man_xtb_167", 32'(xtb), 32'd1);
                     man_req = 1'b0;
    wait_digit(168); chk("man_done", 32'(stopped), 32'd1); chk("man_xtb_off", 32'(xtb), 32'd0);
    wait_digit(192); chk("man_then_s1", 32'(stopped), 32'd0); chk("man_s1_beat", 32'(beat), 32'd0);

    // Asynchronous reset in the middle of a write.
    run = 1'b1; store = 1'b0;
    do_reset();
    wait_digit(95);  store = 1'b1;
    wait_digit(100); chk("ar_xtb_before", 32'(xtb), 32'd1); store = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("ar_xtb_drop", 32'(xtb), 32'd0); chk("ar_stopped", 32'(stopped), 32'd1);
       chk("ar_digit", 32'(digit), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    wait_digit(1);   chk("ar_after", 32'(stopped), 32'd1); chk("ar_dig1", 32'(digit), 32'd1);

    // Randomized phase; every cycle is checked against the model.
    run = 1'b1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      ci       = AW'($urandom);
      pi_addr  = AW'($urandom);
      man_addr = AW'($urandom);
      store    = ($urandom_range(0, 1) == 0);
      halt     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) run = ~run;
      if (man_req && man_ack) man_req = 1'b0;
      else if (!man_req && $urandom_range(0, 149) == 0) man_req = 1'b1;
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ms_beat_controller.md
Name: ms_beat_controller

Overview:
- Beat sequencer for the main store. Divides the w_DPG digit stream into beats of INSTR_BITS + FLYBACK_TIME digits.
- Steps the machine through the four-beat instruction cycle SCAN1, ACTION1, SCAN2, ACTION2.
- Drives the store address, write strobe (w_XTB) and loopback-zero (w_MS_ZERO).
- Arbitrates store access between the running program and the manual (typewriter) write path, which is served only while the machine is stopped.

Parameters:
INSTR_BITS, 20, digits per store line (active digits of a beat)
INSTR_ADDR_BITS, 10, store address width
FLYBACK_TIME, 4, flyback digits appended to each beat

Ports:
w_DPG  in  1  digit pulse clock; all state changes on rising edge
w_RST_N  in  1  asynchronous active-low reset
w_RUN  in  1  run/stop switch level
w_HALT  in  1  present instruction is STOP; sampled at last digit of SCAN2
w_STORE  in  1  present instruction writes store; sampled at last digit of SCAN2
b_CI  in  INSTR_ADDR_BITS  control instruction address
b_PI_ADDR  in  INSTR_ADDR_BITS  operand address field of present instruction
w_MAN_REQ  in  1  manual write request (level, held until ack)
b_MAN_ADDR  in  INSTR_ADDR_BITS  manual/display address
b_MS_ADDR  out  INSTR_ADDR_BITS  store line address
w_XTB  out  1  store write enable
w_MS_ZERO  out  1  suppress loopback so the line is replaced rather than ORed
b_DIGIT  out  $clog2(INSTR_BITS+FLYBACK_TIME)+1  digit within beat
w_FLYBACK  out  1  b_DIGIT >= INSTR_BITS
b_BEAT  out  2  0=SCAN1, 1=ACTION1, 2=SCAN2, 3=ACTION2 (0 in STOP/MAN)
w_CI_INC  out  1  one-digit pulse: increment CI
w_PI_LOAD  out  1  one-digit pulse: load PI from store output
w_MAN_ACK  out  1  one-digit pulse: manual write done
w_STOPPED  out  1  high in STOP

Behaviour:
- Reset (async, w_RST_N=0): state STOP, b_DIGIT=0, latched store/halt flags=0.
- Reset outputs: w_XTB=0, w_MS_ZERO=0, all pulses 0, b_BEAT=0, w_STOPPED=1, b_MS_ADDR=b_MAN_ADDR. Reset mid-beat drops w_XTB immediately.
- Digit counter: runs in every state, including STOP. Counts 0..BEAT_LEN-1 (BEAT_LEN = INSTR_BITS+FLYBACK_TIME), then wraps to 0.
- "Last digit" means b_DIGIT == BEAT_LEN-1. State changes happen only on the edge leaving the last digit, so every beat is exactly BEAT_LEN digits.
- States: STOP, MAN, SCAN1, ACTION1, SCAN2, ACTION2.
- STOP transitions at last digit:
  - w_MAN_REQ=1 -> MAN. Manual wins over w_RUN when both are high.
  - else w_RUN=1 -> SCAN1.
  - else stay in STOP.
- MAN -> STOP. w_MAN_ACK pulses on the last digit of MAN.
- SCAN1 -> ACTION1. w_CI_INC pulses on the last digit of SCAN1.
- ACTION1 -> SCAN2. w_PI_LOAD pulses on the last digit of ACTION1.
- SCAN2 -> ACTION2. On the last digit, latch w_STORE into st_f and w_HALT into hl_f.
- ACTION2 transitions at last digit:
  - hl_f=1 or w_RUN=0 -> STOP.
  - else -> SCAN1.
  - st_f and hl_f clear on exit from ACTION2.
- Dropping w_RUN mid-cycle always completes the current instruction before stopping.
- w_MAN_REQ while running is ignored until STOP is reached, then served at the next beat boundary.
- b_MS_ADDR by state:
  - SCAN1, ACTION1: b_CI.
  - SCAN2, ACTION2: b_PI_ADDR.
  - STOP, MAN: b_MAN_ADDR (display scan).
- w_XTB: high for every digit of MAN, and for every digit of ACTION2 when st_f=1. Low otherwise.
- w_MS_ZERO: identical to w_XTB.
- All outputs are registered or decoded from registered state/counter. No combinational path from any input to w_XTB.
- Pulses are exactly one w_DPG period wide.

Test Plan:
- Reset check (INSTR_BITS=20, FLYBACK_TIME=4, BEAT_LEN=24): hold w_RST_N=0 -> w_STOPPED=1, w_XTB=0, b_DIGIT=0. Release with w_RUN=0 for 100 digits -> b_DIGIT cycles 0..23, w_FLYBACK high at digits 20..23, never leaves STOP.
- Normal cycle: w_RUN=1, b_CI=7, b_PI_ADDR=5, digits counted from reset release.
  - SCAN1 at digits 24..47; w_CI_INC at 47.
  - ACTION1 at 48..71 with b_MS_ADDR=7; w_PI_LOAD at 71.
  - SCAN2/ACTION2 at 72..119 with b_MS_ADDR=5; w_XTB=0 throughout.
  - SCAN1 again at 120.
- Store instruction: w_STORE=1 at digit 95 -> w_XTB=w_MS_ZERO=1 exactly digits 96..119 with b_MS_ADDR=5. w_STORE=0 at digit 95 -> w_XTB stays 0.
- Halt and run drop:
  - w_HALT=1 at digit 95 -> w_STOPPED=1 from digit 120.
  - Separately, w_RUN falls at digit 50 -> ACTION2 completes, then STOP at 120.
- Manual arbitration:
  - w_MAN_REQ=1 and w_RUN=1 together in STOP -> MAN beat, w_XTB high 24 digits at b_MAN_ADDR, one w_MAN_ACK, then SCAN1 next beat only if w_MAN_REQ is dropped.
  - w_MAN_REQ asserted during ACTION1 -> ignored until STOP is reached.
- Async reset mid-write: assert w_RST_N=0 at digit 100 of a store cycle -> w_XTB drops without waiting for a w_DPG edge; after release, STOP with b_DIGIT=0.
